// File: rtl/student_dmux8_dispatcher_pkg.sv
// rtl/student_dmux8_dispatcher_pkg.sv - shared constants, state encoding and helpers for the dispatcher
//
// Contents:
//   N_OUT    - number of consumers (8)
//   SEL_W    - destination index width (3)
//   state_t  - ST_IDLE (empty) / ST_HOLD (one word held)
//   wrap_inc - modulo-8 increment used for the round-robin pointer
package student_dmux8_dispatcher_pkg;

  localparam int N_OUT = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Natural 3-bit overflow gives the 7 -> 0 wrap.
  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/student_dispatch_rr_ptr.sv
// rtl/student_dispatch_rr_ptr.sv - 3-bit wrapping round-robin pointer
//
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset, pointer -> 0
//   advance  - step pointer by one (7 wraps to 0)
//   load     - load load_val (has priority over advance)
//   load_val - value for load
//   ptr      - current pointer
module student_dispatch_rr_ptr
  import student_dmux8_dispatcher_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             load,
  input  logic [SEL_W-1:0] load_val,
  output logic [SEL_W-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (advance) begin
      ptr <= wrap_inc(ptr);
    end
  end

endmodule

// File: rtl/student_dmux8way.sv
// rtl/student_dmux8way.sv - 1-to-8 demultiplexer of a single bit
//
// Ports:
//   in  - bit to steer
//   sel - output index
//   out - out[sel] = in, all other bits 0
module student_dmux8way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic [7:0] out
);

  always_comb begin
    out      = '0;
    out[sel] = in;
  end

endmodule

// File: rtl/student_dmux8_dispatcher.sv
// rtl/student_dmux8_dispatcher.sv - one-word 8-way dispatcher, direct or round-robin destination
//
// Optional feature macro: STUDENT_DISPATCH_CNT_EN (adds dispatch_count handshake counter)
//
// Ports:
//   clk, reset     - clock, asynchronous active-high reset
//   rr_mode        - 1: round-robin destination, 0: use in_dest
//   in_valid/in_ready/in_data/in_dest - producer handshake, word and destination
//   out_data       - held word, shared by all consumers
//   out_valid      - one-hot valid, bit = destination consumer
//   out_ready      - per-consumer ready (only the targeted bit matters)
//   busy           - a word is held
//   dispatch_count - completed output handshakes, wraps (macro only)
module student_dmux8_dispatcher
  import student_dmux8_dispatcher_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rr_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_dest,
  output logic [WIDTH-1:0] out_data,
  output logic [N_OUT-1:0] out_valid,
  input  logic [N_OUT-1:0] out_ready,
  output logic             busy
`ifdef STUDENT_DISPATCH_CNT_EN
  ,
  output logic [15:0]      dispatch_count
`endif
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] target_q;
  logic             rr_cap_q;   // held word was captured in round-robin mode
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_eff;
  logic [SEL_W-1:0] new_target;
  logic             hs;
  logic             accept;

  assign hs     = (state_q == ST_HOLD) && out_ready[target_q];
  assign accept = in_valid && in_ready;

  // A round-robin word leaving this cycle advances the pointer at the same
  // edge, so a word accepted alongside it must already see the advanced value.
  assign rr_eff     = (hs && rr_cap_q) ? wrap_inc(target_q) : rr_ptr;
  assign new_target = rr_mode ? rr_eff : in_dest;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = ST_HOLD;
    end else if (hs) begin
      state_d = ST_IDLE;
    end
  end

  // Output logic
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_HOLD: begin
        busy     = 1'b1;
        in_ready = out_ready[target_q];
      end
      default: ;
    endcase
  end

  // Held word and its destination
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= '0;
      target_q <= '0;
      rr_cap_q <= 1'b0;
    end else if (accept) begin
      out_data <= in_data;
      target_q <= new_target;
      rr_cap_q <= rr_mode;
    end
  end

  student_dispatch_rr_ptr u_rr_ptr (
    .clk      (clk),
    .rst      (reset),
    .advance  (hs && rr_cap_q),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (rr_ptr)
  );

  student_dmux8way u_fanout (
    .in  (busy),
    .sel (target_q),
    .out (out_valid)
  );

`ifdef STUDENT_DISPATCH_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dispatch_count <= '0;
    end else if (hs) begin
      dispatch_count <= dispatch_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_student_dmux8_dispatcher.sv
// tb/tb_student_dmux8_dispatcher.sv - directed self-checking bench for student_dmux8_dispatcher
module tb_student_dmux8_dispatcher;

  logic       clk;
  logic       reset;
  logic       rr_mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic [7:0] out_data;
  logic [7:0] out_valid;
  logic [7:0] out_ready;
  logic       busy;
`ifdef STUDENT_DISPATCH_CNT_EN
  logic [15:0] dispatch_count;
`endif

  int checks;
  int errors;

  student_dmux8_dispatcher #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rr_mode   (rr_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef STUDENT_DISPATCH_CNT_EN
    ,
    .dispatch_count (dispatch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    rr_mode   = 1'b0;
    in_data   = '0;
    in_dest   = '0;
    out_ready = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // ---------------- reset state ----------------
    reset     = 1'b1;
    in_valid  = 1'b0;
    rr_mode   = 1'b0;
    in_data   = '0;
    in_dest   = '0;
    out_ready = '0;
    #2;
    check("rst_out_valid", {8'h0, out_valid}, 16'h0000);
    check("rst_busy", {15'h0, busy}, 16'h0000);
    check("rst_out_data", {8'h0, out_data}, 16'h0000);
    tick();
    reset = 1'b0;
    #1;
    check("rst_in_ready", {15'h0, in_ready}, 16'h0001);

    // ---------------- direct word to 5, stalled 10 cycles ----------------
    rr_mode  = 1'b0;
    in_dest  = 3'd5;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check("dir_out_valid", {8'h0, out_valid}, 16'h0020);
    check("dir_out_data", {8'h0, out_data}, 16'h00A5);
    check("dir_busy", {15'h0, busy}, 16'h0001);
    check("dir_in_ready", {15'h0, in_ready}, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      out_ready = (i >= 5) ? 8'hDF : 8'h00;  // other consumers ready: ignored
      in_data   = 8'h11;
      tick();
      check("stall_valid", {8'h0, out_valid}, 16'h0020);
      check("stall_data", {8'h0, out_data}, 16'h00A5);
    end
    out_ready = 8'h20;
    #1;
    check("dir_hs_in_ready", {15'h0, in_ready}, 16'h0001);
    tick();
    out_ready = 8'h00;
    #1;
    check("dir_done_valid", {8'h0, out_valid}, 16'h0000);
    check("dir_done_busy", {15'h0, busy}, 16'h0000);

    // ---------------- round-robin back-to-back, 10 words ----------------
    do_reset();
    rr_mode   = 1'b1;
    out_ready = 8'hFF;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(i);
      in_dest = 3'd6;  // ignored in round-robin mode
      #1;
      check("rr_in_ready", {15'h0, in_ready}, 16'h0001);
      tick();
      check("rr_out_valid", {8'h0, out_valid}, 16'(8'h01 << (i % 8)));
      check("rr_out_data", {8'h0, out_data}, 16'(i));
    end
    in_valid = 1'b0;
    tick();
    check("rr_drain_valid", {8'h0, out_valid}, 16'h0000);

    // ---------------- stall on target 3, no skip ----------------
    // Pointer is now 2: send one word to 2 and drain it to reach 3.
    in_valid = 1'b1;
    in_data  = 8'h22;
    tick();
    check("rr2_out_valid", {8'h0, out_valid}, 16'h0004);
    in_valid = 1'b0;
    tick();
    out_ready = 8'hF7;
    in_valid  = 1'b1;
    in_data   = 8'h33;
    tick();
    check("rr3_out_valid", {8'h0, out_valid}, 16'h0008);
    in_data = 8'h44;
    #1;
    check("rr3_in_ready", {15'h0, in_ready}, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr3_hold_valid", {8'h0, out_valid}, 16'h0008);
      check("rr3_hold_data", {8'h0, out_data}, 16'h0033);
    end
    out_ready = 8'hFF;
    #1;
    check("rr3_release_ready", {15'h0, in_ready}, 16'h0001);
    tick();
    check("rr4_out_valid", {8'h0, out_valid}, 16'h0010);
    check("rr4_out_data", {8'h0, out_data}, 16'h0044);

    // ---------------- async reset mid-HOLD on output 7 ----------------
    in_data = 8'h55;
    tick();
    check("rr5_out_valid", {8'h0, out_valid}, 16'h0020);
    in_data = 8'h66;
    tick();
    check("rr6_out_valid", {8'h0, out_valid}, 16'h0040);
    in_valid = 1'b0;
    tick();
    out_ready = 8'h00;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    tick();
    in_valid = 1'b0;
    check("rr7_out_valid", {8'h0, out_valid}, 16'h0080);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", {8'h0, out_valid}, 16'h0000);
    check("async_rst_busy", {15'h0, busy}, 16'h0000);
    tick();
    reset = 1'b0;
    #1;
    in_valid = 1'b1;
    in_data  = 8'h88;
    tick();
    in_valid = 1'b0;
    check("post_rst_rr_valid", {8'h0, out_valid}, 16'h0001);

    // ---------------- direct word leaves pointer alone ----------------
    do_reset();
    rr_mode  = 1'b0;
    in_dest  = 3'd2;
    in_data  = 8'hD2;
    in_valid = 1'b1;
    tick();
    check("dir2_out_valid", {8'h0, out_valid}, 16'h0004);
    rr_mode   = 1'b1;
    in_data   = 8'hE0;
    out_ready = 8'h04;
    tick();
    in_valid = 1'b0;
    out_ready = 8'h00;
    #1;
    check("dir_then_rr_valid", {8'h0, out_valid}, 16'h0001);
    check("dir_then_rr_data", {8'h0, out_data}, 16'h00E0);

`ifdef STUDENT_DISPATCH_CNT_EN
    // ---------------- handshake counter ----------------
    do_reset();
    check("cnt_rst", dispatch_count, 16'd0);
    rr_mode   = 1'b1;
    out_ready = 8'hFF;
    in_valid  = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    in_valid = 1'b0;
    tick();
    check("cnt_300", dispatch_count, 16'd300);
    in_valid = 1'b1;
    for (int i = 0; i < 65235; i++) tick();
    in_valid = 1'b0;
    tick();
    check("cnt_65535", dispatch_count, 16'd65535);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("cnt_wrap", dispatch_count, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/student_dmux8_dispatcher.md
Name: student_dmux8_dispatcher

Overview:
- Sequencing controller for an 8-way demultiplexer.
- Accepts data words on a valid/ready input and steers each word to exactly one of 8 consumers.
- Destination comes from a per-word field (direct mode) or a rotating pointer (round-robin mode).
- Registers one word, drives the one-hot output valid through a student_dmux8way fan-out, and holds it until the selected consumer takes it.

Parameters:
- WIDTH, 8, data word width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- rr_mode  input  1  1 = round-robin destination; 0 = use in_dest.
- in_valid  input  1  producer has a word.
- in_ready  output  1  dispatcher can accept a word this cycle.
- in_data  input  WIDTH  producer word.
- in_dest  input  3  destination index, sampled with the word when rr_mode=0.
- out_data  output  WIDTH  held word, shared by all 8 consumers.
- out_valid  output  8  one-hot valid; bit i means the word is for consumer i.
- out_ready  input  8  per-consumer ready.
- busy  output  1  a word is held.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, out_data=0, target=0, rr_ptr=0, busy=0.
  - in_ready is high in the first cycle after reset release.
- States: IDLE (empty) and HOLD (one word held).
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture in_data into out_data.
  - Capture target: in_dest if rr_mode=0, else rr_ptr. rr_mode is sampled at the accept edge only.
  - Go to HOLD.
- HOLD:
  - out_valid = one-hot(target); bit target is the only bit high; busy=1.
  - A handshake completes when out_ready[target]=1. out_ready on other bits is ignored.
  - On handshake: if the capture was round-robin, rr_ptr <= target+1 mod 8 (7 wraps to 0). In direct mode rr_ptr is unchanged.
- Back-to-back:
  - in_ready = IDLE || (HOLD && out_ready[target]).
  - A handshake plus a new accept in the same cycle replaces the word and target and stays in HOLD.
  - Sustained throughput is 1 word/cycle.
  - The round-robin target for the new word uses the already-advanced pointer, so consecutive words go to 0,1,2,...
  - Otherwise the state returns to IDLE and out_valid goes to 0 in the next cycle.
- Latency: word accepted at edge N is visible on out_valid/out_data after edge N (registered), i.e. in cycle N+1.
- Stalled consumer:
  - The word, target and out_valid stay stable indefinitely.
  - out_data must not change while out_valid!=0 without a handshake.
  - No skipping to another consumer.
- in_valid low in HOLD has no effect. in_dest is ignored in round-robin mode.
- Reset asserted mid-HOLD:
  - Immediately (asynchronously) clears out_valid and busy, and drops the held word.
  - rr_ptr returns to 0.
- The out_valid fan-out is student_dmux8way(in=busy, sel=target). No other gating.

Optional Feature:
- Macro: STUDENT_DISPATCH_CNT_EN.
- Defined:
  - Adds output dispatch_count [15:0].
  - Increments by 1 on every completed output handshake and wraps 65535 to 0.
  - Reset value 0, cleared asynchronously by reset.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Decomposition:
- Shared header student_dispatch_defs.vh: N_OUT=8, SEL_W=3, state encodings ST_IDLE=1'b0, ST_HOLD=1'b1.
- One natural sub-module: student_dispatch_rr_ptr.
  - 3-bit wrapping pointer with advance and load inputs.
  - Async reset to 0.
- The fan-out reuses the existing student_dmux8way.

Test Plan:
- Reset, then rr_mode=0, in_dest=5, in_data=0xA5, all out_ready=0:
  - out_valid=8'b0010_0000, out_data=0xA5, held for 10 cycles.
  - Then out_ready[5]=1 for one cycle: out_valid=0 next cycle.
- rr_mode=1, all out_ready=1, 10 back-to-back words 0x00..0x09:
  - Words appear one per cycle on outputs 0,1,...,7,0,1.
  - in_ready stays 1.
- rr_mode=1, target=3 with out_ready=8'b1111_0111:
  - Word stays on output 3 with no skip.
  - Raising out_ready[3] completes it and the next word goes to output 4.
- Word held on output 7 (rr_ptr=7), assert reset mid-HOLD:
  - out_valid=0 and busy=0 asynchronously.
  - After release, the first round-robin word goes to output 0.
- Direct-mode word to output 2, then a round-robin word:
  - rr_ptr is unchanged, so the round-robin word goes to the pre-existing pointer value (0 after reset).
- With STUDENT_DISPATCH_CNT_EN defined, 300 handshakes from reset:
  - dispatch_count=300.
  - A preload variant starting at count 65535 shows wrap to 0 on the next handshake.
